// File: rtl/csr_file_if.sv
`default_nettype none
// ============================================================================
// Module : csr_file_if
// Brief  : Core-to-CSR-file bus: access strobe, address and data, plus trap
//          and mret control with the redirect vector.
// Rev    : 1.0
// ============================================================================
interface csr_file_if;
   logic        csr;
   logic [11:0] csr_rd_addr;
   logic        csr_wr_en;
   logic [31:0] csr_wr_data;
   logic [31:0] csr_rd_data;
   logic        csr_illegal;
   logic [31:0] pc;
   logic        trap;
   logic        mret;
   logic        retire;
   logic [31:0] trap_vector;

   modport master (
      output csr, csr_rd_addr, csr_wr_en, csr_wr_data, pc, trap, mret, retire,
      input  csr_rd_data, csr_illegal, trap_vector
   );

   modport slave (
      input  csr, csr_rd_addr, csr_wr_en, csr_wr_data, pc, trap, mret, retire,
      output csr_rd_data, csr_illegal, trap_vector
   );
endinterface
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module : csr_file
// Brief  : Machine-mode CSR responder with trap/mret handling. Define
//          CSR_COUNTERS_EN to implement the 64-bit mcycle/minstret counters.
// Rev    : 1.0
// ============================================================================
module csr_file #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter logic [31:0] HART_ID     = 32'h0
) (
   input  wire logic   clk,
   input  wire logic   reset,
   csr_file_if.slave   bus
);
   localparam logic [11:0] c_mstatus  = 12'h300;
   localparam logic [11:0] c_misa     = 12'h301;
   localparam logic [11:0] c_mtvec    = 12'h305;
   localparam logic [11:0] c_mscratch = 12'h340;
   localparam logic [11:0] c_mepc     = 12'h341;
   localparam logic [11:0] c_mcause   = 12'h342;
   localparam logic [11:0] c_mhartid  = 12'hF14;
   localparam logic [11:0] c_mcycle   = 12'hB00;
   localparam logic [11:0] c_minstret = 12'hB02;
   localparam logic [11:0] c_mcycleh  = 12'hB80;
   localparam logic [11:0] c_minstrth = 12'hB82;
   localparam logic [11:0] c_cycle    = 12'hC00;
   localparam logic [11:0] c_instret  = 12'hC02;
   localparam logic [11:0] c_cycleh   = 12'hC80;
   localparam logic [11:0] c_instreth = 12'hC82;
   localparam logic [31:0] c_misa_val = 32'h4000_0100;

   logic        mie_q, mie_d, mpie_q, mpie_d;
   logic [29:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
   logic [31:0] mscratch_q, mscratch_d, mcause_q, mcause_d;
   logic [31:0] w_rdata;
   logic        w_mapped, w_ro_write, w_illegal, w_we;

`ifdef CSR_COUNTERS_EN
   logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
   logic        w_inc_instret;
`endif

   always_comb begin
      w_rdata  = 32'h0;
      w_mapped = 1'b1;
      case (bus.csr_rd_addr)
         c_mstatus:  w_rdata = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
         c_misa:     w_rdata = c_misa_val;
         c_mtvec:    w_rdata = {mtvec_q, 2'b00};
         c_mscratch: w_rdata = mscratch_q;
         c_mepc:     w_rdata = {mepc_q, 2'b00};
         c_mcause:   w_rdata = mcause_q;
         c_mhartid:  w_rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
         c_mcycle,   c_cycle:    w_rdata = mcycle_q[31:0];
         c_mcycleh,  c_cycleh:   w_rdata = mcycle_q[63:32];
         c_minstret, c_instret:  w_rdata = minstret_q[31:0];
         c_minstrth, c_instreth: w_rdata = minstret_q[63:32];
`else
         // Counter space stays legal but reads as zero without counters.
         c_mcycle, c_cycle, c_mcycleh, c_cycleh,
         c_minstret, c_instret, c_minstrth, c_instreth: w_rdata = 32'h0;
`endif
         default:    w_mapped = 1'b0;
      endcase
   end

   assign w_ro_write = bus.csr_wr_en &&
                       ((bus.csr_rd_addr[11:10] == 2'b11) || (bus.csr_rd_addr == c_misa));
   assign w_illegal  = bus.csr & (~w_mapped | w_ro_write);
   assign w_we       = bus.csr & bus.csr_wr_en & ~w_illegal & ~bus.trap;

   assign bus.csr_rd_data = bus.csr ? w_rdata : 32'h0;
   assign bus.csr_illegal = w_illegal;
   assign bus.trap_vector = bus.trap ? {mtvec_q, 2'b00} :
                            bus.mret ? {mepc_q, 2'b00}  : 32'h0;

   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      if (w_we) begin
         case (bus.csr_rd_addr)
            c_mstatus: begin
               mie_d  = bus.csr_wr_data[3];
               mpie_d = bus.csr_wr_data[7];
            end
            c_mtvec:    mtvec_d    = bus.csr_wr_data[31:2];
            c_mscratch: mscratch_d = bus.csr_wr_data;
            c_mepc:     mepc_d     = bus.csr_wr_data[31:2];
            c_mcause:   mcause_d   = bus.csr_wr_data;
            default: ;
         endcase
      end
      if (bus.mret) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end
      // Trap overrides both mret and any CSR write in the same cycle.
      if (bus.trap) begin
         mepc_d   = bus.pc[31:2];
         mcause_d = 32'd3;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtvec_q    <= MTVEC_RESET[31:2];
         mscratch_q <= 32'h0;
         mepc_q     <= 30'h0;
         mcause_q   <= 32'h0;
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
      end
   end

`ifdef CSR_COUNTERS_EN
   assign w_inc_instret = bus.retire & ~bus.trap;

   // A write to either half replaces the increment for the whole counter.
   always_comb begin
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = minstret_q + {63'd0, w_inc_instret};
      if (w_we) begin
         case (bus.csr_rd_addr)
            c_mcycle:   mcycle_d   = {mcycle_q[63:32], bus.csr_wr_data};
            c_mcycleh:  mcycle_d   = {bus.csr_wr_data, mcycle_q[31:0]};
            c_minstret: minstret_d = {minstret_q[63:32], bus.csr_wr_data};
            c_minstrth: minstret_d = {bus.csr_wr_data, minstret_q[31:0]};
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcycle_q   <= 64'h0;
         minstret_q <= 64'h0;
      end else begin
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end
`endif

   logic unused_bits;
   assign unused_bits = ^{bus.pc[1:0], bus.retire};

endmodule
`default_nettype wire
